// File: rtl/mtsp_cache_tag_nway.sv
// N-way set-associative tag directory with round-robin replacement
// and a one-set-per-cycle invalidate sweep.
module mtsp_cache_tag_nway #(
  parameter int WAYS        = 4,
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 20,
  localparam int WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   LUT_CLEAR,
  output logic                   BUSY,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic                   REQ_ALLOC,
  input  logic [INDEX_WIDTH-1:0] REQ_INDEX,
  input  logic [TAG_WIDTH-1:0]   REQ_TAG,
  output logic                   RSP_VALID,
  output logic                   RSP_HIT,
  output logic [WAY_BITS-1:0]    RSP_WAY,
  output logic                   RSP_EVICT,
  output logic [TAG_WIDTH-1:0]   RSP_EVICT_TAG
);

  localparam int SETS = 1 << INDEX_WIDTH;

  logic                   busy_q, busy_d;
  logic [INDEX_WIDTH-1:0] swp_q, swp_d;

  logic [SETS-1:0][WAYS-1:0] vld_q, vld_d;
  logic [TAG_WIDTH-1:0]      tag_q [SETS][WAYS];
  logic [TAG_WIDTH-1:0]      tag_d [SETS][WAYS];
  logic [WAY_BITS-1:0]       rr_q  [SETS];
  logic [WAY_BITS-1:0]       rr_d  [SETS];

  logic                   s1_vld_q, s1_vld_d;
  logic                   s1_kill_q, s1_kill_d;
  logic                   s1_alloc_q, s1_alloc_d;
  logic [INDEX_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d;

  logic                 r_vld_q, r_vld_d;
  logic                 r_hit_q, r_hit_d;
  logic [WAY_BITS-1:0]  r_way_q, r_way_d;
  logic                 r_ev_q, r_ev_d;
  logic [TAG_WIDTH-1:0] r_etag_q, r_etag_d;

  logic                 o_vld_q, o_vld_d;
  logic                 o_hit_q, o_hit_d;
  logic [WAY_BITS-1:0]  o_way_q, o_way_d;
  logic                 o_ev_q, o_ev_d;
  logic [TAG_WIDTH-1:0] o_etag_q, o_etag_d;

  logic                hit, inv_found, live;
  logic [WAY_BITS-1:0] hit_way, inv_way, victim, rr_cur, rr_nxt;

  assign BUSY          = busy_q;
  assign REQ_READY     = ~busy_q;
  assign RSP_VALID     = o_vld_q;
  assign RSP_HIT       = o_hit_q;
  assign RSP_WAY       = o_way_q;
  assign RSP_EVICT     = o_ev_q;
  assign RSP_EVICT_TAG = o_etag_q;

  // Lookup reads committed state; the previous request already wrote.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld_q[s1_idx_q][w] &&
          tag_q[s1_idx_q][w] == s1_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!vld_q[s1_idx_q][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    rr_cur = rr_q[s1_idx_q];
    rr_nxt = (rr_cur == WAY_BITS'(WAYS - 1)) ?
             '0 : rr_cur + WAY_BITS'(1);
    victim = inv_found ? inv_way : rr_cur;
    live   = s1_vld_q & ~s1_kill_q & ~LUT_CLEAR;
  end

  always_comb begin
    s1_vld_d   = REQ_VALID & ~busy_q;
    s1_kill_d  = LUT_CLEAR;
    s1_alloc_d = REQ_ALLOC;
    s1_idx_d   = REQ_INDEX;
    s1_tag_d   = REQ_TAG;

    vld_d  = vld_q;
    tag_d  = tag_q;
    rr_d   = rr_q;
    busy_d = busy_q;
    swp_d  = swp_q;

    r_vld_d  = s1_vld_q;
    r_hit_d  = 1'b0;
    r_way_d  = '0;
    r_ev_d   = 1'b0;
    r_etag_d = '0;

    if (live) begin
      if (hit) begin
        r_hit_d = 1'b1;
        r_way_d = hit_way;
      end else if (s1_alloc_q) begin
        r_way_d = victim;
        r_ev_d  = ~inv_found;
        if (!inv_found) begin
          r_etag_d         = tag_q[s1_idx_q][victim];
          rr_d[s1_idx_q]   = rr_nxt;
        end
        vld_d[s1_idx_q][victim] = 1'b1;
        tag_d[s1_idx_q][victim] = s1_tag_q;
      end
    end

    if (busy_q) begin
      vld_d[swp_q] = '0;
      rr_d[swp_q]  = '0;
      swp_d        = swp_q + INDEX_WIDTH'(1);
      if (&swp_q) busy_d = 1'b0;
    end
    if (LUT_CLEAR) begin
      busy_d = 1'b1;
      swp_d  = '0;
    end

    // A clear also blanks the response already past the lookup.
    o_vld_d  = r_vld_q;
    o_hit_d  = r_hit_q & ~LUT_CLEAR;
    o_way_d  = LUT_CLEAR ? '0 : r_way_q;
    o_ev_d   = r_ev_q & ~LUT_CLEAR;
    o_etag_d = LUT_CLEAR ? '0 : r_etag_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q     <= 1'b1;
      swp_q      <= '0;
      vld_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
      s1_vld_q   <= 1'b0;
      s1_kill_q  <= 1'b0;
      s1_alloc_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_tag_q   <= '0;
      r_vld_q    <= 1'b0;
      r_hit_q    <= 1'b0;
      r_way_q    <= '0;
      r_ev_q     <= 1'b0;
      r_etag_q   <= '0;
      o_vld_q    <= 1'b0;
      o_hit_q    <= 1'b0;
      o_way_q    <= '0;
      o_ev_q     <= 1'b0;
      o_etag_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      swp_q      <= swp_d;
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      rr_q       <= rr_d;
      s1_vld_q   <= s1_vld_d;
      s1_kill_q  <= s1_kill_d;
      s1_alloc_q <= s1_alloc_d;
      s1_idx_q   <= s1_idx_d;
      s1_tag_q   <= s1_tag_d;
      r_vld_q    <= r_vld_d;
      r_hit_q    <= r_hit_d;
      r_way_q    <= r_way_d;
      r_ev_q     <= r_ev_d;
      r_etag_q   <= r_etag_d;
      o_vld_q    <= o_vld_d;
      o_hit_q    <= o_hit_d;
      o_way_q    <= o_way_d;
      o_ev_q     <= o_ev_d;
      o_etag_q   <= o_etag_d;
    end
  end

endmodule

// File: tb/tb_mtsp_cache_tag_nway.sv
// Directed vector bench for mtsp_cache_tag_nway (4 ways, 64 sets).
module tb_mtsp_cache_tag_nway;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        LUT_CLEAR = 1'b0;
  logic        BUSY;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_ALLOC = 1'b0;
  logic [5:0]  REQ_INDEX = '0;
  logic [19:0] REQ_TAG = '0;
  logic        RSP_VALID;
  logic        RSP_HIT;
  logic [1:0]  RSP_WAY;
  logic        RSP_EVICT;
  logic [19:0] RSP_EVICT_TAG;

  int n_tests = 0;
  int n_fail  = 0;

  mtsp_cache_tag_nway #(
    .WAYS(4), .INDEX_WIDTH(6), .TAG_WIDTH(20)
  ) dut (
    .CLK(CLK), .nRST(nRST), .LUT_CLEAR(LUT_CLEAR), .BUSY(BUSY),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ALLOC(REQ_ALLOC), .REQ_INDEX(REQ_INDEX),
    .REQ_TAG(REQ_TAG), .RSP_VALID(RSP_VALID), .RSP_HIT(RSP_HIT),
    .RSP_WAY(RSP_WAY), .RSP_EVICT(RSP_EVICT),
    .RSP_EVICT_TAG(RSP_EVICT_TAG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic        alloc;
    logic [5:0]  idx;
    logic [19:0] tag;
    logic        hit;
    logic [1:0]  way;
    logic        ev;
    logic [19:0] etag;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic v, input logic al, input int idx,
                     input int tag, input logic hit, input int way,
                     input logic ev, input int etag);
    vec_t e;
    e.v = v; e.alloc = al; e.idx = 6'(idx); e.tag = 20'(tag);
    e.hit = hit; e.way = 2'(way); e.ev = ev; e.etag = 20'(etag);
    tv.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] rsp_now();
    return 64'({RSP_VALID, RSP_HIT, RSP_WAY, RSP_EVICT, RSP_EVICT_TAG});
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi + 2; i++) begin
      if (i <= hi) begin
        REQ_VALID = tv[i].v;
        REQ_ALLOC = tv[i].alloc;
        REQ_INDEX = tv[i].idx;
        REQ_TAG   = tv[i].tag;
      end else begin
        REQ_VALID = 1'b0;
        REQ_ALLOC = 1'b0;
      end
      @(posedge CLK); #1;
      if (i - 2 >= lo) begin
        vec_t e;
        e = tv[i-2];
        chk($sformatf("vec%0d", i - 2), rsp_now(),
            64'({e.v, e.hit, e.way, e.ev, e.etag}));
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (!REQ_READY && cnt < 200) begin
      @(posedge CLK); #1;
      cnt++;
    end
    chk(name, 64'(cnt), 64'd64);
  endtask

  initial begin
    // v alloc idx tag | hit way ev etag
    add(1, 1,  3, 'h12345, 0, 0, 0, 0);     // 0
    add(1, 0,  3, 'h12345, 1, 0, 0, 0);
    add(1, 1,  7, 'hA,     0, 0, 0, 0);
    add(1, 1,  7, 'hB,     0, 1, 0, 0);
    add(1, 1,  7, 'hC,     0, 2, 0, 0);
    add(1, 1,  7, 'hD,     0, 3, 0, 0);     // 5
    add(1, 1,  7, 'hE,     0, 0, 1, 'hA);
    add(1, 1,  7, 'hF,     0, 1, 1, 'hB);
    add(1, 0,  7, 'hA,     0, 0, 0, 0);
    add(1, 0,  7, 'hE,     1, 0, 0, 0);
    add(1, 1,  5, 'hAA,    0, 0, 0, 0);     // 10
    add(1, 0,  5, 'hAA,    1, 0, 0, 0);
    add(1, 0,  9, 'h55,    0, 0, 0, 0);
    add(1, 0,  9, 'h55,    0, 0, 0, 0);
    add(1, 1,  7, 'hA,     0, 2, 1, 'hC);
    add(1, 0,  7, 'hC,     0, 0, 0, 0);     // 15
    add(1, 0,  3, 'h0,     0, 0, 0, 0);
    add(1, 1,  3, 'h12345, 1, 0, 0, 0);
    add(1, 1, 11, 'h77,    0, 0, 0, 0);
    add(0, 0,  0, 'h0,     0, 0, 0, 0);
    add(1, 0, 11, 'h77,    1, 0, 0, 0);     // 20
    add(1, 1,  0, 'h100,   0, 0, 0, 0);
    add(1, 1,  0, 'h101,   0, 1, 0, 0);
    add(1, 1,  0, 'h102,   0, 2, 0, 0);
    add(1, 1,  0, 'h103,   0, 3, 0, 0);
    // after the clear sweep
    add(1, 0,  0, 'h100,   0, 0, 0, 0);     // 25
    add(1, 0,  0, 'h103,   0, 0, 0, 0);
    add(1, 0,  7, 'hE,     0, 0, 0, 0);
    add(1, 1,  0, 'h100,   0, 0, 0, 0);
    add(1, 0,  0, 'h100,   1, 0, 0, 0);
    // after mid-operation reset
    add(1, 0,  2, 'h9,     0, 0, 0, 0);     // 30

    @(posedge CLK); #1;
    chk("reset_busy", 64'({BUSY, REQ_READY}), 64'b10);
    chk("reset_rsp", rsp_now(), 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    wait_ready("reset_sweep_len");

    run_vecs(0, 24);

    // Two in flight as the clear pulse lands: one queued, one coincident.
    REQ_VALID = 1'b1; REQ_ALLOC = 1'b0;
    REQ_INDEX = 6'd0; REQ_TAG = 20'h100;
    @(posedge CLK); #1;
    REQ_TAG = 20'h101; LUT_CLEAR = 1'b1;
    chk("clr_ready_coincident", 64'(REQ_READY), 64'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; LUT_CLEAR = 1'b0;
    chk("clr_busy", 64'({BUSY, REQ_READY}), 64'b10);
    begin
      int cnt;
      cnt = 0;
      while (!REQ_READY && cnt < 200) begin
        @(posedge CLK); #1;
        cnt++;
        if (cnt == 1) chk("clr_inflight0", rsp_now(),
                          64'({1'b1, 1'b0, 2'd0, 1'b0, 20'd0}));
        if (cnt == 2) chk("clr_inflight1", rsp_now(),
                          64'({1'b1, 1'b0, 2'd0, 1'b0, 20'd0}));
      end
      chk("clr_sweep_len", 64'(cnt), 64'd64);
    end

    run_vecs(25, 29);

    // Reset while an allocation is in flight.
    REQ_VALID = 1'b1; REQ_ALLOC = 1'b1;
    REQ_INDEX = 6'd2; REQ_TAG = 20'h9;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    chk("midreset_rsp", rsp_now(), 64'd0);
    chk("midreset_busy", 64'({BUSY, REQ_READY}), 64'b10);
    @(posedge CLK); #1;
    chk("midreset_hold", rsp_now(), 64'd0);
    nRST = 1'b1;
    wait_ready("midreset_sweep_len");

    run_vecs(30, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
